// File: rtl/par_fifo_pkg.sv
// rtl/par_fifo_pkg.sv - shared helpers for the parallel circular FIFO
package par_fifo_pkg;

  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/circ_ptr_adv.sv
// rtl/circ_ptr_adv.sv - modular pointer advance: (ptr + step) mod DEPTH
module circ_ptr_adv
  import par_fifo_pkg::*;
#(
  parameter int DEPTH  = 10,
  parameter int STEP_W = 3
) (
  input  logic [clog2_min1(DEPTH)-1:0] ptr,
  input  logic [STEP_W-1:0]            step,
  output logic [clog2_min1(DEPTH)-1:0] nxt
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int SUM_W = ((STEP_W > PTR_W) ? STEP_W : PTR_W) + 1;

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] wrapped;

  // ptr < DEPTH and step <= DEPTH, so a single conditional subtract wraps
  assign sum     = SUM_W'(ptr) + SUM_W'(step);
  assign wrapped = (sum >= SUM_W'(DEPTH)) ? (sum - SUM_W'(DEPTH)) : sum;
  assign nxt     = PTR_W'(wrapped);

endmodule

// File: rtl/par_circular_fifo.sv
// rtl/par_circular_fifo.sv - multi-lane circular FIFO with all-or-nothing acceptance
module par_circular_fifo
  import par_fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 10,
  parameter int WR_LANES = 4,
  parameter int RD_LANES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_req,
  input  logic [$clog2(WR_LANES+1)-1:0]  wr_num,
  input  logic [WR_LANES*WIDTH-1:0]      wr_data,
  output logic                           wr_ack,
  input  logic                           rd_req,
  input  logic [$clog2(RD_LANES+1)-1:0]  rd_num,
  output logic [RD_LANES*WIDTH-1:0]      rd_data,
  output logic                           rd_ack,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty,
  output logic                           err_ovf,
  output logic                           err_udf,
  input  logic                           clr_err
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int WN_W  = $clog2(WR_LANES+1);
  localparam int RN_W  = $clog2(RD_LANES+1);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_addr [WR_LANES];
  logic [PTR_W-1:0] rd_addr [RD_LANES];
  logic [CNT_W-1:0] space, wr_inc, rd_dec;
  logic             wr_legal, rd_legal;

  // Checks use the pre-cycle count only; same-cycle frees/fills are not credited
  assign space    = CNT_W'(DEPTH) - count;
  assign wr_legal = (32'(wr_num) <= WR_LANES);
  assign rd_legal = (32'(rd_num) <= RD_LANES);
  assign wr_ack   = ~rst & wr_req & wr_legal & (32'(wr_num) <= 32'(space));
  assign rd_ack   = ~rst & rd_req & rd_legal & (32'(rd_num) <= 32'(count));
  assign wr_inc   = wr_ack ? CNT_W'(wr_num) : '0;
  assign rd_dec   = rd_ack ? CNT_W'(rd_num) : '0;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  circ_ptr_adv #(.DEPTH(DEPTH), .STEP_W(WN_W)) u_wr_adv (
    .ptr(wr_ptr), .step(wr_num), .nxt(wr_ptr_nxt)
  );
  circ_ptr_adv #(.DEPTH(DEPTH), .STEP_W(RN_W)) u_rd_adv (
    .ptr(rd_ptr), .step(rd_num), .nxt(rd_ptr_nxt)
  );

  for (genvar i = 0; i < WR_LANES; i++) begin : g_wr_lane
    circ_ptr_adv #(.DEPTH(DEPTH), .STEP_W(WN_W)) u_adv (
      .ptr(wr_ptr), .step(WN_W'(i)), .nxt(wr_addr[i])
    );
  end

  for (genvar i = 0; i < RD_LANES; i++) begin : g_rd_lane
    circ_ptr_adv #(.DEPTH(DEPTH), .STEP_W(RN_W)) u_adv (
      .ptr(rd_ptr), .step(RN_W'(i)), .nxt(rd_addr[i])
    );
    assign rd_data[i*WIDTH +: WIDTH] = mem[rd_addr[i]];
  end

  always_ff @(posedge clk) begin
    if (wr_ack) begin
      for (int i = 0; i < WR_LANES; i++) begin
        if (i < 32'(wr_num)) mem[wr_addr[i]] <= wr_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (wr_ack) wr_ptr <= wr_ptr_nxt;
      if (rd_ack) rd_ptr <= rd_ptr_nxt;
      count   <= count + wr_inc - rd_dec;
      // a new error in the same cycle as clr_err keeps the flag set
      err_ovf <= (wr_req & ~wr_ack) | (err_ovf & ~clr_err);
      err_udf <= (rd_req & ~rd_ack) | (err_udf & ~clr_err);
    end
  end

  assert property (@(posedge clk) disable iff (rst) wr_req |-> wr_legal);
  assert property (@(posedge clk) disable iff (rst) rd_req |-> rd_legal);

endmodule
